wb_xbar_arb: RTL and testbench
==============================

Name: wb_xbar_arb

Overview:
Multi-master, multi-slave pipelined Wishbone interconnect. It is the successor to the single-master shared bus. It adds:
- round-robin arbitration between masters;
- tracking of outstanding pipelined requests, with in-order response routing;
- an internal error responder for unmapped addresses;
- a response watchdog.

It sits between the CPU/DMA masters and the peripheral/memory slaves of the SoC.

Parameters:
WB_DATA_WIDTH, 8, data bus width
WB_ADDR_WIDTH, 16, address bus width
WB_NUM_MASTERS, 2, number of masters (>=1)
WB_NUM_SLAVES, 1, number of slaves (>=1)
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (power of two, >=1)
TIMEOUT_CYCLES, 255, idle-response cycles before the watchdog fires (>=2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
mstr_cyc_i/mstr_lock_i/mstr_stb_i/mstr_we_i  in  WB_NUM_MASTERS each  per-master Wishbone control
mstr_adr_i  in  WB_ADDR_WIDTH*WB_NUM_MASTERS  packed master addresses
mstr_dat_i  in  WB_DATA_WIDTH*WB_NUM_MASTERS  packed master write data
mstr_stall_o/mstr_ack_o/mstr_err_o  out  WB_NUM_MASTERS each  per-master stall/ack/error
mstr_dat_o  out  WB_DATA_WIDTH*WB_NUM_MASTERS  packed read data
bus_slv_addr_decode_value/bus_slv_addr_decode_mask  in  WB_ADDR_WIDTH*WB_NUM_SLAVES each  slave i selected when (mask_i & adr) == value_i
slv_cyc_o/slv_lock_o/slv_stb_o/slv_we_o  out  WB_NUM_SLAVES each  slave control
slv_adr_o  out  WB_ADDR_WIDTH*WB_NUM_SLAVES  slave addresses
slv_dat_o  out  WB_DATA_WIDTH*WB_NUM_SLAVES  slave write data
slv_stall_i/slv_ack_i/slv_err_i  in  WB_NUM_SLAVES each  slave stall/ack/error
slv_dat_i  in  WB_DATA_WIDTH*WB_NUM_SLAVES  packed slave read data

Behaviour:
Reset:
- rst_n_i low clears all state immediately: arbiter IDLE, last_grant = WB_NUM_MASTERS-1, FIFO empty, watchdog 0.
- During reset: all slv_cyc/stb = 0, all mstr_ack/err = 0, mstr_dat_o = 0, mstr_stall_o = 1.

Arbiter FSM (IDLE, OWNED):
- IDLE: if any mstr_cyc_i is high, grant the first requester searching from last_grant+1 upward, with wrap-around. Register it as owner and go to OWNED. Arbitration latency is 1 cycle, so the winner sees stall = 0 from the next cycle.
- OWNED: stays OWNED while owner cyc = 1.
- Owner cyc = 0 with owner lock = 1: remain OWNED for the same master; no other master is granted.
- Owner cyc = 0 with lock = 0: go to IDLE, set last_grant = owner, flush the FIFO, clear the watchdog.
- Non-owner masters: stall = 1, ack = 0, err = 0, dat = 0.

Request path (combinational from owner):
- slv_cyc_o, slv_lock_o, slv_we_o, slv_adr_o and slv_dat_o are broadcast to all slaves from the owner. slv_cyc_o = 0 in IDLE.
- Decode: the lowest-index matching slave wins. No match means unmapped.
- slv_stb_o[s] = owner stb & selected(s) & ~fifo_full.
- Owner stall = fifo_full | (mapped ? slv_stall_i[s] : 0).
- Accepted request = owner stb & ~owner stall. It pushes {unmapped flag, slave index} into the FIFO.

Response path:
- The FIFO head selects the responding slave. slv_ack_i/err_i/dat_i of the head slave go to the owner. Responses from non-head slaves are ignored.
- Any ack or err pops the FIFO.
- An unmapped head produces err = 1 for one cycle, earliest the cycle after acceptance, then pops.
- mstr_dat_o = 0 unless ack = 1.
- Push and pop in the same cycle leave the count unchanged. Push while full cannot occur, because stall blocks it.
- ack and err from the same slave in the same cycle: err wins, one pop.

Watchdog:
- Increments each cycle while the FIFO is non-empty and no pop occurs. Cleared on pop or when the FIFO is empty.
- On reaching TIMEOUT_CYCLES: one-cycle err to the owner, pop the head, clear the counter.

Abort:
- An owner cyc drop with outstanding entries flushes them. Late slave acks are not forwarded.

Test Plan:
- Reset: hold rst_n_i = 0 mid-transfer for 3 cycles -> all slv_stb/cyc = 0, mstr_ack = 0, FIFO empty, next grant goes to master 0.
- Round robin: 2 masters, both cyc = 1, each drops cyc after 1 access -> grant sequence M0, M1, M0, M1; each grant takes 1 cycle of arbitration latency.
- Pipelining: 4 back-to-back reads to slave 1, acks 2 cycles later returning 0x11, 0x22, 0x33, 0x44 -> 4 acks in order with that data, no stall. A 5th request while 4 are outstanding -> stall = 1 until the first ack.
- Unmapped: write to an address matching no decode entry -> stall = 0, err = 1 the next cycle, no slv_stb asserted.
- Watchdog: slave never acks, TIMEOUT_CYCLES = 8 -> err to the master exactly 8 cycles after acceptance, FIFO empty afterwards.
- Lock: M0 holds lock = 1 and drops cyc for 2 cycles while M1 requests -> M1 stays stalled until M0 releases lock.

Source files
------------

// File: rtl/wb_xbar_arb.sv
// Pipelined Wishbone interconnect: round-robin master ownership, address decode to N slaves,
// in-order response routing through an outstanding-request FIFO, error responder and watchdog.
module wb_xbar_arb #(
  parameter int unsigned WB_DATA_WIDTH   = 8,
  parameter int unsigned WB_ADDR_WIDTH   = 16,
  parameter int unsigned WB_NUM_MASTERS  = 2,
  parameter int unsigned WB_NUM_SLAVES   = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_cyc_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_lock_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_stb_i,
  input  logic [WB_NUM_MASTERS-1:0]               mstr_we_i,
  input  logic [WB_ADDR_WIDTH*WB_NUM_MASTERS-1:0] mstr_adr_i,
  input  logic [WB_DATA_WIDTH*WB_NUM_MASTERS-1:0] mstr_dat_i,
  output logic [WB_NUM_MASTERS-1:0]               mstr_stall_o,
  output logic [WB_NUM_MASTERS-1:0]               mstr_ack_o,
  output logic [WB_NUM_MASTERS-1:0]               mstr_err_o,
  output logic [WB_DATA_WIDTH*WB_NUM_MASTERS-1:0] mstr_dat_o,
  input  logic [WB_ADDR_WIDTH*WB_NUM_SLAVES-1:0]  bus_slv_addr_decode_value,
  input  logic [WB_ADDR_WIDTH*WB_NUM_SLAVES-1:0]  bus_slv_addr_decode_mask,
  output logic [WB_NUM_SLAVES-1:0]                slv_cyc_o,
  output logic [WB_NUM_SLAVES-1:0]                slv_lock_o,
  output logic [WB_NUM_SLAVES-1:0]                slv_stb_o,
  output logic [WB_NUM_SLAVES-1:0]                slv_we_o,
  output logic [WB_ADDR_WIDTH*WB_NUM_SLAVES-1:0]  slv_adr_o,
  output logic [WB_DATA_WIDTH*WB_NUM_SLAVES-1:0]  slv_dat_o,
  input  logic [WB_NUM_SLAVES-1:0]                slv_stall_i,
  input  logic [WB_NUM_SLAVES-1:0]                slv_ack_i,
  input  logic [WB_NUM_SLAVES-1:0]                slv_err_i,
  input  logic [WB_DATA_WIDTH*WB_NUM_SLAVES-1:0]  slv_dat_i
);

  localparam int unsigned DW = WB_DATA_WIDTH;
  localparam int unsigned AW = WB_ADDR_WIDTH;
  localparam int unsigned MW = (WB_NUM_MASTERS > 1) ? $clog2(WB_NUM_MASTERS) : 1;
  localparam int unsigned SW = (WB_NUM_SLAVES > 1) ? $clog2(WB_NUM_SLAVES) : 1;
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {S_IDLE, S_OWNED} state_t;

  typedef struct packed {
    logic          unmapped;
    logic [SW-1:0] slv;
  } fifo_entry_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   owner_q, owner_d;
  logic [MW-1:0]   last_grant_q, last_grant_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   wd_q, wd_d;
  fifo_entry_t     fifo_q [MAX_OUTSTANDING];
  fifo_entry_t     fifo_d [MAX_OUTSTANDING];

  logic            active, own_cyc, own_lock, own_stb, own_we;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;
  logic            mapped, sel_stall;
  logic [SW-1:0]   sel;
  logic            fifo_empty, fifo_full, own_stall, push, pop;
  fifo_entry_t     head;
  logic            head_valid, hd_ack, hd_err, slv_rsp, timeout;
  logic [DW-1:0]   hd_dat;
  logic            rsp_ack, rsp_err, bus_release;
  logic [MW-1:0]   winner;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Owner request mux
  always_comb begin
    own_cyc  = 1'b0;
    own_lock = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_adr  = '0;
    own_dat  = '0;
    for (int m = 0; m < int'(WB_NUM_MASTERS); m++) begin
      if (MW'(m) == owner_q) begin
        own_cyc  = mstr_cyc_i[m];
        own_lock = mstr_lock_i[m];
        own_stb  = mstr_stb_i[m];
        own_we   = mstr_we_i[m];
        own_adr  = mstr_adr_i[m*AW +: AW];
        own_dat  = mstr_dat_i[m*DW +: DW];
      end
    end
  end

  // Address decode: scanning downward lets the lowest matching slave win
  always_comb begin
    mapped = 1'b0;
    sel    = '0;
    for (int s = int'(WB_NUM_SLAVES) - 1; s >= 0; s--) begin
      if ((bus_slv_addr_decode_mask[s*AW +: AW] & own_adr) == bus_slv_addr_decode_value[s*AW +: AW]) begin
        mapped = 1'b1;
        sel    = SW'(s);
      end
    end
  end

  // Selected-slave stall and FIFO-head response mux
  always_comb begin
    sel_stall = 1'b0;
    hd_ack    = 1'b0;
    hd_err    = 1'b0;
    hd_dat    = '0;
    for (int s = 0; s < int'(WB_NUM_SLAVES); s++) begin
      if (SW'(s) == sel) sel_stall = slv_stall_i[s];
      if (SW'(s) == head.slv) begin
        hd_ack = slv_ack_i[s];
        hd_err = slv_err_i[s];
        hd_dat = slv_dat_i[s*DW +: DW];
      end
    end
  end

  // Round-robin pick: lowest requester above last_grant, else lowest requester overall
  always_comb begin
    logic          found_hi;
    logic [MW-1:0] pick_hi, pick_lo;
    found_hi = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int m = int'(WB_NUM_MASTERS) - 1; m >= 0; m--) begin
      if (mstr_cyc_i[m]) begin
        pick_lo = MW'(m);
        if (MW'(m) > last_grant_q) begin
          pick_hi  = MW'(m);
          found_hi = 1'b1;
        end
      end
    end
    winner = found_hi ? pick_hi : pick_lo;
  end

  assign active      = (state_q == S_OWNED);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(MAX_OUTSTANDING));
  assign own_stall   = fifo_full | (mapped & sel_stall);
  assign push        = active & own_cyc & own_stb & ~own_stall;
  assign head        = fifo_q[rd_ptr_q];
  assign head_valid  = active & own_cyc & ~fifo_empty;
  assign slv_rsp     = head_valid & (head.unmapped | hd_ack | hd_err);
  assign timeout     = head_valid & ~slv_rsp & (wd_q == TW'(TIMEOUT_CYCLES - 1));
  assign pop         = slv_rsp | timeout;
  assign rsp_err     = head_valid & (head.unmapped | hd_err | timeout);
  assign rsp_ack     = head_valid & ~head.unmapped & hd_ack & ~hd_err;
  assign bus_release = active & ~own_cyc & ~own_lock;

  // Arbiter, FIFO and watchdog next state
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wd_d         = wd_q;
    fifo_d       = fifo_q;

    case (state_q)
      S_IDLE: begin
        if (|mstr_cyc_i) begin
          state_d = S_OWNED;
          owner_d = winner;
        end
      end
      S_OWNED: begin
        if (bus_release) begin
          state_d      = S_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus_release) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      wd_d     = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q].unmapped = ~mapped;
        fifo_d[wr_ptr_q].slv      = sel;
        wr_ptr_d                  = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      wd_d = (head_valid && !pop) ? wd_q + TW'(1) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_grant_q <= MW'(WB_NUM_MASTERS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wd_q         <= '0;
      fifo_q       <= '{default: '0};
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wd_q         <= wd_d;
      fifo_q       <= fifo_d;
    end
  end

  // Master-side responses; non-owners see a stalled, silent bus
  always_comb begin
    mstr_stall_o = '1;
    mstr_ack_o   = '0;
    mstr_err_o   = '0;
    mstr_dat_o   = '0;
    for (int m = 0; m < int'(WB_NUM_MASTERS); m++) begin
      if (active && (MW'(m) == owner_q)) begin
        mstr_stall_o[m] = own_stall;
        mstr_ack_o[m]   = rsp_ack;
        mstr_err_o[m]   = rsp_err;
        if (rsp_ack) mstr_dat_o[m*DW +: DW] = hd_dat;
      end
    end
  end

  // Slave-side request broadcast
  always_comb begin
    slv_cyc_o  = {WB_NUM_SLAVES{active & own_cyc}};
    slv_lock_o = {WB_NUM_SLAVES{active & own_lock}};
    slv_we_o   = {WB_NUM_SLAVES{own_we}};
    slv_adr_o  = {WB_NUM_SLAVES{own_adr}};
    slv_dat_o  = {WB_NUM_SLAVES{own_dat}};
    slv_stb_o  = '0;
    for (int s = 0; s < int'(WB_NUM_SLAVES); s++) begin
      slv_stb_o[s] = active & own_cyc & own_stb & mapped & (sel == SW'(s)) & ~fifo_full;
    end
  end

endmodule

// File: tb/tb_wb_xbar_arb.sv
// Directed bench for wb_xbar_arb: 2 masters, 2 slaves (0x0xxx, 0x1xxx), 4 outstanding, timeout 8.
module tb_wb_xbar_arb;

  logic        clk_i;
  logic        rst_n_i;
  logic [1:0]  m_cyc, m_lock, m_stb, m_we;
  logic [31:0] m_adr;
  logic [15:0] m_dat;
  logic [1:0]  mstr_stall_o, mstr_ack_o, mstr_err_o;
  logic [15:0] mstr_dat_o;
  logic [31:0] dec_value, dec_mask;
  logic [1:0]  slv_cyc_o, slv_lock_o, slv_stb_o, slv_we_o;
  logic [31:0] slv_adr_o;
  logic [15:0] slv_dat_o;
  logic [1:0]  s_stall, s_ack, s_err;
  logic [15:0] s_dat;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] rd_data [4];

  wb_xbar_arb #(
    .WB_DATA_WIDTH  (8),
    .WB_ADDR_WIDTH  (16),
    .WB_NUM_MASTERS (2),
    .WB_NUM_SLAVES  (2),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i                    (clk_i),
    .rst_n_i                  (rst_n_i),
    .mstr_cyc_i               (m_cyc),
    .mstr_lock_i              (m_lock),
    .mstr_stb_i               (m_stb),
    .mstr_we_i                (m_we),
    .mstr_adr_i               (m_adr),
    .mstr_dat_i               (m_dat),
    .mstr_stall_o             (mstr_stall_o),
    .mstr_ack_o               (mstr_ack_o),
    .mstr_err_o               (mstr_err_o),
    .mstr_dat_o               (mstr_dat_o),
    .bus_slv_addr_decode_value(dec_value),
    .bus_slv_addr_decode_mask (dec_mask),
    .slv_cyc_o                (slv_cyc_o),
    .slv_lock_o               (slv_lock_o),
    .slv_stb_o                (slv_stb_o),
    .slv_we_o                 (slv_we_o),
    .slv_adr_o                (slv_adr_o),
    .slv_dat_o                (slv_dat_o),
    .slv_stall_i              (s_stall),
    .slv_ack_i                (s_ack),
    .slv_err_i                (s_err),
    .slv_dat_i                (s_dat)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge; outputs are checked at the falling edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc   = '0;
    m_lock  = '0;
    m_stb   = '0;
    m_we    = '0;
    m_adr   = '0;
    m_dat   = '0;
    s_stall = '0;
    s_ack   = '0;
    s_err   = '0;
    s_dat   = '0;
  endtask

  task automatic apply_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    step();
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b11) $display("FAIL rst_stall: got %b want 11", mstr_stall_o); else n_pass++;
    n_total++; if (slv_cyc_o !== 2'b00) $display("FAIL rst_cyc: got %b want 00", slv_cyc_o); else n_pass++;
    step();
    rst_n_i  = 1'b1;
    m_cyc[1] = 1'b1;
    step();
    m_stb[1]       = 1'b1;
    m_adr[31:16]   = 16'h0040;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b01) $display("FAIL rst_pre_grant_m1: got %b want 01", mstr_stall_o); else n_pass++;
    step();
    // Mid-transfer: both masters active and a slave ack pending when reset hits
    m_cyc    = 2'b11;
    m_stb    = 2'b11;
    s_ack[0] = 1'b1;
    s_dat    = 16'h00AA;
    rst_n_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_total++; if (slv_cyc_o !== 2'b00 || slv_stb_o !== 2'b00) $display("FAIL rst_slv_idle: cyc %b stb %b want 00 00", slv_cyc_o, slv_stb_o); else n_pass++;
      n_total++; if (mstr_ack_o !== 2'b00 || mstr_err_o !== 2'b00) $display("FAIL rst_mstr_rsp: ack %b err %b want 00 00", mstr_ack_o, mstr_err_o); else n_pass++;
      n_total++; if (mstr_stall_o !== 2'b11 || mstr_dat_o !== 16'h0000) $display("FAIL rst_mstr_out: stall %b dat %h want 11 0000", mstr_stall_o, mstr_dat_o); else n_pass++;
      step();
    end
    rst_n_i = 1'b1;
    m_stb   = 2'b00;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b11) $display("FAIL rst_idle_after: got %b want 11", mstr_stall_o); else n_pass++;
    step();
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b10) $display("FAIL rst_grant_m0: got %b want 10", mstr_stall_o); else n_pass++;
    n_total++; if (mstr_ack_o !== 2'b00) $display("FAIL rst_fifo_empty: ack %b want 00", mstr_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_round_robin();
    int g;
    apply_reset();
    m_adr = {16'h0020, 16'h0010};
    for (int i = 0; i < 4; i++) begin
      g     = i % 2;
      m_cyc = 2'b11;
      m_stb = 2'b11;
      @(negedge clk_i);
      n_total++; if (mstr_stall_o !== 2'b11) $display("FAIL rr_arb_latency[%0d]: got %b want 11", i, mstr_stall_o); else n_pass++;
      step();
      @(negedge clk_i);
      n_total++; if (mstr_stall_o !== ((g == 1) ? 2'b01 : 2'b10)) $display("FAIL rr_grant[%0d]: stall %b want master %0d", i, mstr_stall_o, g); else n_pass++;
      n_total++; if (slv_adr_o[15:0] !== ((g == 1) ? 16'h0020 : 16'h0010)) $display("FAIL rr_adr[%0d]: got %h", i, slv_adr_o[15:0]); else n_pass++;
      step();
      m_stb[g]   = 1'b0;
      s_ack[0]   = 1'b1;
      s_dat[7:0] = 8'h50 + 8'(g);
      @(negedge clk_i);
      n_total++; if (mstr_ack_o !== ((g == 1) ? 2'b10 : 2'b01)) $display("FAIL rr_ack[%0d]: got %b", i, mstr_ack_o); else n_pass++;
      n_total++; if (mstr_dat_o[g*8 +: 8] !== 8'h50 + 8'(g)) $display("FAIL rr_dat[%0d]: got %h want %h", i, mstr_dat_o[g*8 +: 8], 8'h50 + 8'(g)); else n_pass++;
      step();
      s_ack[0] = 1'b0;
      m_cyc[g] = 1'b0;
      m_stb[g] = 1'b0;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_pipelining();
    rd_data[0] = 8'h11;
    rd_data[1] = 8'h22;
    rd_data[2] = 8'h33;
    rd_data[3] = 8'h44;
    m_cyc[0] = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      m_stb[0]    = (k < 4);
      m_adr[15:0] = 16'h1000 + 16'(k);
      s_ack[1]    = (k >= 2);
      s_dat[15:8] = (k >= 2) ? rd_data[k-2] : 8'h00;
      @(negedge clk_i);
      if (k < 4) begin
        n_total++; if (mstr_stall_o[0] !== 1'b0) $display("FAIL pipe_stall[%0d]: got %b want 0", k, mstr_stall_o[0]); else n_pass++;
        n_total++; if (slv_stb_o !== 2'b10) $display("FAIL pipe_stb[%0d]: got %b want 10", k, slv_stb_o); else n_pass++;
      end
      if (k >= 2) begin
        n_total++; if (mstr_ack_o !== 2'b01) $display("FAIL pipe_ack[%0d]: got %b want 01", k, mstr_ack_o); else n_pass++;
        n_total++; if (mstr_dat_o[7:0] !== rd_data[k-2]) $display("FAIL pipe_dat[%0d]: got %h want %h", k, mstr_dat_o[7:0], rd_data[k-2]); else n_pass++;
      end
      step();
    end
    // Fill the FIFO without acking; the fifth request must wait for the first ack
    s_ack = '0;
    s_dat = '0;
    for (int j = 0; j < 8; j++) begin
      m_stb[0]    = 1'b1;
      m_adr[15:0] = 16'h1004;
      s_ack[1]    = (j == 6);
      s_dat[15:8] = (j == 6) ? 8'h55 : 8'h00;
      @(negedge clk_i);
      if (j < 4 || j == 7) begin
        n_total++; if (mstr_stall_o[0] !== 1'b0) $display("FAIL full_nostall[%0d]: got %b want 0", j, mstr_stall_o[0]); else n_pass++;
      end else begin
        n_total++; if (mstr_stall_o[0] !== 1'b1) $display("FAIL full_stall[%0d]: got %b want 1", j, mstr_stall_o[0]); else n_pass++;
      end
      if (j == 4) begin
        n_total++; if (slv_stb_o !== 2'b00) $display("FAIL full_stb: got %b want 00", slv_stb_o); else n_pass++;
      end
      if (j == 6) begin
        n_total++; if (mstr_ack_o !== 2'b01 || mstr_dat_o[7:0] !== 8'h55) $display("FAIL full_ack: ack %b dat %h want 01 55", mstr_ack_o, mstr_dat_o[7:0]); else n_pass++;
      end
      step();
    end
    m_stb[0] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      s_ack[1] = 1'b1;
      s_dat[15:8] = 8'h60 + 8'(n);
      @(negedge clk_i);
      n_total++; if (mstr_ack_o !== ((n < 4) ? 2'b01 : 2'b00)) $display("FAIL drain_ack[%0d]: got %b", n, mstr_ack_o); else n_pass++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_unmapped();
    m_cyc[0] = 1'b1;
    step();
    m_stb[0]    = 1'b1;
    m_we[0]     = 1'b1;
    m_adr[15:0] = 16'h2000;
    m_dat[7:0]  = 8'h99;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o[0] !== 1'b0) $display("FAIL unm_stall: got %b want 0", mstr_stall_o[0]); else n_pass++;
    n_total++; if (slv_stb_o !== 2'b00) $display("FAIL unm_stb: got %b want 00", slv_stb_o); else n_pass++;
    n_total++; if (mstr_err_o !== 2'b00) $display("FAIL unm_err_early: got %b want 00", mstr_err_o); else n_pass++;
    step();
    m_stb[0] = 1'b0;
    @(negedge clk_i);
    n_total++; if (mstr_err_o !== 2'b01 || mstr_ack_o !== 2'b00) $display("FAIL unm_err: err %b ack %b want 01 00", mstr_err_o, mstr_ack_o); else n_pass++;
    step();
    m_stb[0]    = 1'b1;
    m_we[0]     = 1'b0;
    m_adr[15:0] = 16'h0005;
    @(negedge clk_i);
    n_total++; if (mstr_err_o !== 2'b00) $display("FAIL unm_err_once: got %b want 00", mstr_err_o); else n_pass++;
    step();
    m_stb[0]   = 1'b0;
    s_ack[0]   = 1'b1;
    s_err[0]   = 1'b1;
    s_dat[7:0] = 8'hEE;
    @(negedge clk_i);
    n_total++; if (mstr_err_o !== 2'b01 || mstr_ack_o !== 2'b00) $display("FAIL err_wins: err %b ack %b want 01 00", mstr_err_o, mstr_ack_o); else n_pass++;
    n_total++; if (mstr_dat_o !== 16'h0000) $display("FAIL err_dat: got %h want 0000", mstr_dat_o); else n_pass++;
    step();
    s_err[0] = 1'b0;
    @(negedge clk_i);
    n_total++; if (mstr_ack_o !== 2'b00) $display("FAIL err_single_pop: ack %b want 00", mstr_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_watchdog();
    m_cyc[0] = 1'b1;
    step();
    m_stb[0]    = 1'b1;
    m_adr[15:0] = 16'h1000;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o[0] !== 1'b0) $display("FAIL wd_accept: stall %b want 0", mstr_stall_o[0]); else n_pass++;
    step();
    m_stb[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      n_total++; if (mstr_err_o !== ((c == 8) ? 2'b01 : 2'b00)) $display("FAIL wd_err[%0d]: got %b", c, mstr_err_o); else n_pass++;
      step();
    end
    s_ack[1] = 1'b1;
    @(negedge clk_i);
    n_total++; if (mstr_err_o !== 2'b00 || mstr_ack_o !== 2'b00) $display("FAIL wd_empty: err %b ack %b want 00 00", mstr_err_o, mstr_ack_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_lock();
    m_cyc[0]  = 1'b1;
    m_lock[0] = 1'b1;
    step();
    m_stb[0]    = 1'b1;
    m_adr[15:0] = 16'h0008;
    m_cyc[1]    = 1'b1;
    m_stb[1]    = 1'b1;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b10) $display("FAIL lock_own: got %b want 10", mstr_stall_o); else n_pass++;
    step();
    m_stb[0] = 1'b0;
    s_ack[0] = 1'b1;
    @(negedge clk_i);
    n_total++; if (mstr_ack_o !== 2'b01) $display("FAIL lock_ack: got %b want 01", mstr_ack_o); else n_pass++;
    step();
    s_ack[0] = 1'b0;
    m_cyc[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      n_total++; if (mstr_stall_o[1] !== 1'b1 || slv_cyc_o !== 2'b00) $display("FAIL lock_hold[%0d]: stall1 %b cyc %b want 1 00", c, mstr_stall_o[1], slv_cyc_o); else n_pass++;
      step();
    end
    m_lock[0] = 1'b0;
    @(negedge clk_i);
    n_total++; if (mstr_stall_o[1] !== 1'b1) $display("FAIL lock_release: stall1 %b want 1", mstr_stall_o[1]); else n_pass++;
    step();
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b11) $display("FAIL lock_idle: got %b want 11", mstr_stall_o); else n_pass++;
    step();
    @(negedge clk_i);
    n_total++; if (mstr_stall_o !== 2'b01) $display("FAIL lock_grant_m1: got %b want 01", mstr_stall_o); else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    rst_n_i   = 1'b0;
    dec_value = {16'h1000, 16'h0000};
    dec_mask  = {16'hF000, 16'hF000};
    idle_inputs();
    test_reset();
    test_round_robin();
    test_pipelining();
    test_unmapped();
    test_watchdog();
    test_lock();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
